// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    // Bit positions of the stage-control vector.
    localparam int unsigned CTL_W             = 8;
    localparam int unsigned CTL_PC_WE         = 0;
    localparam int unsigned CTL_PC_SEL        = 1;
    localparam int unsigned CTL_IF_ID_WE      = 2;
    localparam int unsigned CTL_IF_ID_FLUSH   = 3;
    localparam int unsigned CTL_ID_EX_WE      = 4;
    localparam int unsigned CTL_ID_EX_FLUSH   = 5;
    localparam int unsigned CTL_EX_MEM_WE     = 6;
    localparam int unsigned CTL_MEM_WB_BUBBLE = 7;

    typedef logic [CTL_W-1:0] ctl_t;

    // Build a control vector from named stage controls.
    function automatic ctl_t ctl_bits(
        input logic pc_we,
        input logic pc_sel,
        input logic if_id_we,
        input logic if_id_flush,
        input logic id_ex_we,
        input logic id_ex_flush,
        input logic ex_mem_we,
        input logic mem_wb_bubble
    );
        ctl_t c;
        c                    = '0;
        c[CTL_PC_WE]         = pc_we;
        c[CTL_PC_SEL]        = pc_sel;
        c[CTL_IF_ID_WE]      = if_id_we;
        c[CTL_IF_ID_FLUSH]   = if_id_flush;
        c[CTL_ID_EX_WE]      = id_ex_we;
        c[CTL_ID_EX_FLUSH]   = id_ex_flush;
        c[CTL_EX_MEM_WE]     = ex_mem_we;
        c[CTL_MEM_WB_BUBBLE] = mem_wb_bubble;
        return c;
    endfunction

    localparam ctl_t CTL_RUN    = ctl_bits(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    localparam ctl_t CTL_HOLD   = ctl_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam ctl_t CTL_FREEZE = ctl_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    localparam ctl_t CTL_BRANCH = ctl_bits(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam ctl_t CTL_LOAD   = ctl_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam ctl_t CTL_RESET  = ctl_bits(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard requests in, per-stage pipeline controls out.
interface pipeline_hazard_controller_if;

    logic load_use_stall;
    logic branch_taken_ex;
    logic dmem_req;
    logic dmem_ready;
    logic halt_req;

    logic pc_write_en;
    logic pc_sel_branch;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_write_en;
    logic id_ex_flush;
    logic ex_mem_write_en;
    logic mem_wb_bubble;

    // Controller side: consumes requests, drives stage controls.
    modport master (
        input  load_use_stall, branch_taken_ex, dmem_req, dmem_ready, halt_req,
        output pc_write_en, pc_sel_branch, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_write_en, mem_wb_bubble
    );

    // Pipeline side: raises requests, obeys stage controls.
    modport slave (
        output load_use_stall, branch_taken_ex, dmem_req, dmem_ready, halt_req,
        input  pc_write_en, pc_sel_branch, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_write_en, mem_wb_bubble
    );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increments, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline control sequencer: stalls, flushes, memory wait, halt and watchdog.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_hazard_controller_if.master  bus,
    output logic                          halted,
    output logic                          mem_fault,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              fault_set;
    logic              stall_inc;
    logic              flush_inc;
    logic              run_rules;
    ctl_t              ctl_c;

    // State, wait counter and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (fault_set) begin
                mem_fault <= 1'b1;
            end
        end
    end

    // Next state and Mealy stage controls; halt beats memory wait beats branch beats load-use.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        fault_set = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        run_rules = 1'b0;
        ctl_c     = CTL_RUN;

        unique case (state)
            ST_RUN: begin
                if (bus.halt_req) begin
                    ctl_c     = CTL_HOLD;
                    state_nxt = ST_HALTED;
                end else if (bus.dmem_req && !bus.dmem_ready) begin
                    ctl_c     = CTL_FREEZE;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                    stall_inc = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    ctl_c     = CTL_FREEZE;
                    stall_inc = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        fault_set = 1'b1;
                        state_nxt = ST_HALTED;
                        wait_nxt  = '0;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Access completes: behave as RUN this cycle, halt_req deferred.
                    wait_nxt  = '0;
                    state_nxt = ST_RUN;
                    run_rules = 1'b1;
                end
            end
            ST_HALTED: begin
                ctl_c = CTL_HOLD;
            end
            default: begin
                ctl_c     = CTL_HOLD;
                state_nxt = ST_RUN;
            end
        endcase

        // A taken branch squashes ID, so a coincident load-use request is moot.
        if (run_rules) begin
            if (bus.branch_taken_ex) begin
                ctl_c     = CTL_BRANCH;
                flush_inc = 1'b1;
            end else if (bus.load_use_stall) begin
                ctl_c     = CTL_LOAD;
                stall_inc = 1'b1;
            end
        end

        if (rst) begin
            ctl_c = CTL_RESET;
        end
    end

    assign halted = (state == ST_HALTED);

    assign bus.pc_write_en     = ctl_c[CTL_PC_WE];
    assign bus.pc_sel_branch   = ctl_c[CTL_PC_SEL];
    assign bus.if_id_write_en  = ctl_c[CTL_IF_ID_WE];
    assign bus.if_id_flush     = ctl_c[CTL_IF_ID_FLUSH];
    assign bus.id_ex_write_en  = ctl_c[CTL_ID_EX_WE];
    assign bus.id_ex_flush     = ctl_c[CTL_ID_EX_FLUSH];
    assign bus.ex_mem_write_en = ctl_c[CTL_EX_MEM_WE];
    assign bus.mem_wb_bubble   = ctl_c[CTL_MEM_WB_BUBBLE];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus randomized run against a cycle model.
module tb_pipeline_hazard_controller;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 3;
    localparam int          CMAX    = 7;

    // Expected control vectors, order {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble}.
    localparam logic [7:0] E_RUN    = 8'b1010_1010;
    localparam logic [7:0] E_HOLD   = 8'b0000_0000;
    localparam logic [7:0] E_FREEZE = 8'b0000_0001;
    localparam logic [7:0] E_BR     = 8'b1111_1110;
    localparam logic [7:0] E_LU     = 8'b0000_1110;
    localparam logic [7:0] E_RST    = 8'b0001_0101;

    logic          clk;
    logic          rst;
    logic          halted;
    logic          mem_fault;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic [7:0]    obs_ctl;

    int checks = 0;
    int errors = 0;

    // Reference model: committed state and next-cycle values.
    bit m_halted = 0, m_wait = 0, m_fault = 0;
    int m_wlen = 0, m_stall = 0, m_flush = 0;
    bit n_halted, n_wait, n_fault;
    int n_wlen, n_stall, n_flush;
    logic [7:0] exp_ctl;

    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .halted       (halted),
        .mem_fault    (mem_fault),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    assign obs_ctl = {bus.pc_write_en, bus.pc_sel_branch, bus.if_id_write_en, bus.if_id_flush,
                      bus.id_ex_write_en, bus.id_ex_flush, bus.ex_mem_write_en, bus.mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and compute what the pipeline should see.
    task automatic apply(input logic r, input logic lu, input logic br,
                         input logic req, input logic rdy, input logic hr);
        bit frz, hold, rules;
        rst = r;
        bus.load_use_stall  = lu;
        bus.branch_taken_ex = br;
        bus.dmem_req        = req;
        bus.dmem_ready      = rdy;
        bus.halt_req        = hr;
        n_halted = m_halted; n_wait = m_wait; n_wlen = m_wlen;
        n_fault = m_fault; n_stall = m_stall; n_flush = m_flush;
        frz = 0; hold = 0; rules = 0;
        if (r) begin
            exp_ctl = E_RST;
            n_halted = 0; n_wait = 0; n_wlen = 0; n_fault = 0; n_stall = 0; n_flush = 0;
        end else begin
            if (m_halted) begin
                hold = 1;
            end else if (m_wait) begin
                if (!rdy) begin
                    frz = 1;
                    n_wlen = m_wlen + 1;
                    if (n_wlen > int'(TIMEOUT)) begin
                        n_fault = 1; n_halted = 1; n_wait = 0;
                    end
                end else begin
                    rules = 1; n_wait = 0;
                end
            end else if (hr) begin
                hold = 1; n_halted = 1;
            end else if (req && !rdy) begin
                frz = 1; n_wait = 1; n_wlen = 1;
            end else begin
                rules = 1;
            end
            exp_ctl = hold ? E_HOLD : frz ? E_FREEZE : (rules && br) ? E_BR :
                      (rules && lu) ? E_LU : E_RUN;
            if (frz || (rules && !br && lu)) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (rules && br) n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end
    endtask

    // Advance one clock edge and commit the model.
    task automatic tick();
        @(posedge clk);
        m_halted = n_halted; m_wait = n_wait; m_wlen = n_wlen;
        m_fault = n_fault; m_stall = n_stall; m_flush = n_flush;
        #1;
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0); #3;
        checks++;
        if (obs_ctl !== E_RST) begin errors++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, E_RST); end
        tick();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if ({halted, mem_fault, stall_cycles, flush_count} !== {2'b00, CW'(0), CW'(0)}) begin
            errors++; $display("FAIL reset_state: halted %b fault %b stall %0d flush %0d want all 0",
                                halted, mem_fault, stall_cycles, flush_count);
        end
        checks++;
        if (obs_ctl !== E_RUN) begin errors++; $display("FAIL reset_run_ctl: got %b want %b", obs_ctl, E_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        apply(0, 1, 0, 0, 0, 0); #3;
        checks++;
        if (obs_ctl !== E_LU) begin errors++; $display("FAIL load_use_ctl: got %b want %b", obs_ctl, E_LU); end
        tick();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if (stall_cycles !== CW'(1)) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cycles); end
        checks++;
        if (obs_ctl !== E_RUN) begin errors++; $display("FAIL load_use_after: got %b want %b", obs_ctl, E_RUN); end
        tick();
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        apply(0, 1, 1, 0, 0, 0); #3;
        checks++;
        if (obs_ctl !== E_BR) begin errors++; $display("FAIL branch_ctl: got %b want %b", obs_ctl, E_BR); end
        tick();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if ({flush_count, stall_cycles} !== {CW'(1), CW'(0)}) begin
            errors++; $display("FAIL branch_counts: flush %0d stall %0d want 1 0", flush_count, stall_cycles);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 0, 0); #3;
            checks++;
            if (obs_ctl !== E_FREEZE) begin errors++; $display("FAIL mem_wait_freeze%0d: got %b want %b", i, obs_ctl, E_FREEZE); end
            tick();
        end
        apply(0, 0, 0, 1, 1, 0); #3;
        checks++;
        if (obs_ctl !== E_RUN) begin errors++; $display("FAIL mem_ready_ctl: got %b want %b", obs_ctl, E_RUN); end
        checks++;
        if (stall_cycles !== CW'(3)) begin errors++; $display("FAIL mem_wait_stall_cnt: got %0d want 3", stall_cycles); end
        tick();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if (obs_ctl !== E_RUN) begin errors++; $display("FAIL mem_back_to_run: got %b want %b", obs_ctl, E_RUN); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            apply(0, 0, 0, 1, 0, 0); #3;
            checks++;
            if ({obs_ctl, mem_fault} !== {E_FREEZE, 1'b0}) begin
                errors++; $display("FAIL timeout_wait%0d: ctl %b fault %b want %b 0", i, obs_ctl, mem_fault, E_FREEZE);
            end
            tick();
        end
        apply(0, 1, 1, 1, 1, 1); #3;
        checks++;
        if ({mem_fault, halted} !== 2'b11) begin errors++; $display("FAIL timeout_fault: fault %b halted %b want 1 1", mem_fault, halted); end
        checks++;
        if (stall_cycles !== CW'(5)) begin errors++; $display("FAIL timeout_stall_cnt: got %0d want 5", stall_cycles); end
        checks++;
        if (obs_ctl !== E_HOLD) begin errors++; $display("FAIL timeout_hold: got %b want %b", obs_ctl, E_HOLD); end
        tick();
        apply(0, 0, 0, 0, 1, 0); #3;
        checks++;
        if (obs_ctl !== E_HOLD) begin errors++; $display("FAIL timeout_hold2: got %b want %b", obs_ctl, E_HOLD); end
        tick();
        do_reset();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if ({mem_fault, halted} !== 2'b00) begin errors++; $display("FAIL timeout_cleared: fault %b halted %b want 0 0", mem_fault, halted); end
        tick();
    endtask

    task automatic test_halt_in_wait();
        do_reset();
        apply(0, 1, 0, 0, 0, 0); tick();
        apply(0, 0, 1, 0, 0, 0); tick();
        apply(0, 0, 0, 1, 0, 1); #3;
        checks++;
        if (obs_ctl !== E_HOLD) begin errors++; $display("FAIL halt_priority: got %b want %b", obs_ctl, E_HOLD); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 1, 1, 0, 0); #3;
            checks++;
            if ({halted, obs_ctl, stall_cycles, flush_count} !== {1'b1, E_HOLD, CW'(1), CW'(1)}) begin
                errors++; $display("FAIL halt_frozen%0d: halted %b ctl %b stall %0d flush %0d want 1 %b 1 1",
                                    i, halted, obs_ctl, stall_cycles, flush_count, E_HOLD);
            end
            tick();
        end
        do_reset();
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if ({halted, obs_ctl, stall_cycles, flush_count} !== {1'b0, E_RUN, CW'(0), CW'(0)}) begin
            errors++; $display("FAIL halt_reset: halted %b ctl %b stall %0d flush %0d want 0 %b 0 0",
                                halted, obs_ctl, stall_cycles, flush_count, E_RUN);
        end
        tick();
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            apply(0, 1, 0, 0, 0, 0); #3;
            want = (i - 1 > CMAX) ? CMAX : i - 1;
            checks++;
            if (stall_cycles !== CW'(want)) begin errors++; $display("FAIL sat_step%0d: got %0d want %0d", i, stall_cycles, want); end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0); #3;
        checks++;
        if (stall_cycles !== CW'(CMAX)) begin errors++; $display("FAIL sat_hold: got %0d want %0d", stall_cycles, CMAX); end
        tick();
    endtask

    task automatic test_random();
        logic r, lu, br, req, rdy, hr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r   = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            lu  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 1) == 0);
            rdy = ($urandom_range(0, 4) < 2);
            hr  = ($urandom_range(0, 39) == 0);
            apply(r, lu, br, req, rdy, hr); #3;
            checks++;
            if ({obs_ctl, halted, mem_fault, stall_cycles, flush_count} !==
                {exp_ctl, 1'(m_halted), 1'(m_fault), CW'(m_stall), CW'(m_flush)}) begin
                errors++;
                $display("FAIL random_cyc%0d: ctl %b halted %b fault %b stall %0d flush %0d want %b %b %b %0d %0d",
                         i, obs_ctl, halted, mem_fault, stall_cycles, flush_count,
                         exp_ctl, m_halted, m_fault, m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load_use_stall = 1'b0; bus.branch_taken_ex = 1'b0; bus.dmem_req = 1'b0;
        bus.dmem_ready = 1'b0; bus.halt_req = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_wait();
        test_timeout();
        test_halt_in_wait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central pipeline control sequencer, the consumer of the hazard detection unit's stall request and of the EX-stage branch resolution and data-memory handshake. Converts those requests into per-stage write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Owns the multi-cycle memory-wait and halt state machine, a memory timeout watchdog, and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive memory-wait cycles before fault; must be >=1.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
load_use_stall  in  1  load-use hazard request from hazard detection (combinational, ID stage)
branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle
dmem_req  in  1  MEM stage accessing data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
halt_req  in  1  ecall/ebreak retiring; held by source until halted=1
pc_write_en  out  1  PC register load enable
pc_sel_branch  out  1  PC loads branch target instead of PC+4
if_id_write_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_write_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads bubble (all control bits 0)
ex_mem_write_en  out  1  EX/MEM register enable
mem_wb_bubble  out  1  MEM/WB loads bubble
halted  out  1  pipeline stopped
mem_fault  out  1  memory timeout occurred (sticky until reset)
stall_cycles  out  CNT_W  cycles lost to load-use or memory wait
flush_count  out  CNT_W  branch flush events

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk. Only those two are shared with the rest of the design.
- Registered: state, wait_cnt, mem_fault, stall_cycles, flush_count. Stage controls are combinational (Mealy) from state and inputs, zero latency.
- While rst=1: all *_write_en=0, if_id_flush=id_ex_flush=mem_wb_bubble=1, pc_sel_branch=0. After the clock edge with rst=1: state=RUN, wait_cnt=0, halted=0, mem_fault=0, counters=0.
- States: RUN, MEM_WAIT, HALTED.
- RUN, default: all write enables=1, flushes/bubble=0, pc_sel_branch=0.
- RUN priority, highest first: halt_req > memory wait > branch > load-use.
- halt_req in RUN: all enables=0, no flushes; next state HALTED.
- Memory wait (dmem_req=1, dmem_ready=0): pc/if_id/id_ex/ex_mem write enables=0, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt=1, stall_cycles+1.
- Branch (branch_taken_ex=1): pc_write_en=1, pc_sel_branch=1, if_id_flush=1, id_ex_flush=1, flush_count+1. A concurrent load_use_stall is ignored because the instruction in ID is squashed.
- Load-use only: pc_write_en=0, if_id_write_en=0, id_ex_flush=1, ex_mem_write_en=1, stall_cycles+1. Lasts one cycle with no extra state; the request deasserts naturally.
- MEM_WAIT, dmem_ready=0: same freeze outputs as memory wait; wait_cnt+1, stall_cycles+1. If wait_cnt==MEM_TIMEOUT: mem_fault<=1, next state HALTED.
- MEM_WAIT, dmem_ready=1: outputs as RUN for this cycle, with branch and load-use rules applied to the inputs; wait_cnt<=0, next state RUN. halt_req is not sampled in MEM_WAIT; it is honoured in RUN next cycle.
- HALTED: all enables=0, flushes=0, halted=1. Leaves only on rst.
- Counters saturate at all-ones and never wrap. Load-use and memory wait do not double count within a cycle.
- rst mid-MEM_WAIT or in HALTED: returns to RUN and clears fault and counters.

Decomposition:
- Shared package/constants file: state encodings (ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_HALTED=2'd2) and the stage-control bit positions.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice for stall_cycles and flush_count.

Test Plan:
1. load_use_stall=1 for one cycle in RUN -> same cycle pc_write_en=0, if_id_write_en=0, id_ex_flush=1; stall_cycles=1 after the edge; next cycle all enables=1.
2. branch_taken_ex=1 together with load_use_stall=1 -> pc_write_en=1, pc_sel_branch=1, if_id_flush=id_ex_flush=1; flush_count=1, stall_cycles=0.
3. dmem_req=1, dmem_ready low for 3 cycles then high -> 3 freeze cycles with mem_wb_bubble=1, stall_cycles=3; the ready cycle has enables=1 and state returns to RUN.
4. MEM_TIMEOUT=4, dmem_ready held 0 -> mem_fault=1 and halted=1 after the 5th wait cycle; all enables stay 0 until rst.
5. halt_req=1 with dmem_req=1, dmem_ready=0 in RUN -> next state HALTED, halted=1, counters frozen; rst=1 for one cycle -> RUN, counters=0.
6. CNT_W=3, 9 consecutive load-use cycles -> stall_cycles holds at 7 with no wrap.
